// File: rtl/conv_a2_sequencer_if.sv
// Control/strobe bundle between the ConvA2 sequencer (master) and the
// convolution unit, its memories and the RISC-V start/done port (slave).
interface conv_a2_sequencer_if #(
    parameter int unsigned ADDRESS_BITS     = 15,
    parameter int unsigned ADDRESS_SIZE_IFM = 10,
    parameter int unsigned ADDRESS_SIZE_OFM = 13
);
    logic                        start;
    logic                        ifm_enable_read;
    logic [ADDRESS_SIZE_IFM-1:0] ifm_address;
    logic                        fifo_enable;
    logic                        conv_enable;
    logic                        wm_enable_read;
    logic                        wm_fifo_enable;
    logic [ADDRESS_BITS-1:0]     wm_address;
    logic                        ofm_enable_write;
    logic [ADDRESS_SIZE_OFM-1:0] ofm_address;
    logic                        busy;
    logic                        done;

    modport master (
        input  start,
        output ifm_enable_read, ifm_address, fifo_enable, conv_enable,
               wm_enable_read, wm_fifo_enable, wm_address,
               ofm_enable_write, ofm_address, busy, done
    );

    modport slave (
        output start,
        input  ifm_enable_read, ifm_address, fifo_enable, conv_enable,
               wm_enable_read, wm_fifo_enable, wm_address,
               ofm_enable_write, ofm_address, busy, done
    );
endinterface

// File: rtl/conv_a2_sequencer.sv
// Layer-pass sequencer for one ConvA2 unit: per filter loads weights, streams
// the IFM, flags valid windows and issues OFM writes aligned to the unit output.
module conv_a2_sequencer #(
    parameter int unsigned IFM_SIZE          = 32,
    parameter int unsigned KERNAL_SIZE       = 5,
    parameter int unsigned NUMBER_OF_FILTERS = 6,
    parameter int unsigned ADDRESS_BITS      = 15,
    parameter int unsigned CONV_LATENCY      = 2,
    parameter int unsigned IFM_SIZE_NEXT     = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int unsigned ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int unsigned ADDRESS_SIZE_OFM  = $clog2(NUMBER_OF_FILTERS * IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                clk,
    input  logic                reset,
    conv_a2_sequencer_if.master bus
);
    localparam int unsigned K2        = KERNAL_SIZE * KERNAL_SIZE;
    localparam int unsigned N2        = IFM_SIZE * IFM_SIZE;
    localparam int unsigned NEXT2     = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int unsigned DRAIN_LEN = CONV_LATENCY + 2;
    localparam int unsigned CNT_W     = $clog2(K2 + N2 + DRAIN_LEN);
    localparam int unsigned RC_W      = $clog2(IFM_SIZE + 1);
    localparam int unsigned FLT_W     = $clog2(NUMBER_OF_FILTERS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_WM, S_STREAM, S_DRAIN, S_NEXT} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [RC_W-1:0]             r_q, r_d, c_q, c_d;
    logic [FLT_W-1:0]            filter_q, filter_d;
    logic                        win_c;
    logic [ADDRESS_SIZE_OFM-1:0] ofm_address_q, ofm_address_d;

    logic                        wm_enable_read_q, wm_fifo_enable_q;
    logic [ADDRESS_BITS-1:0]     wm_address_q;
    logic                        ifm_enable_read_q, fifo_enable_q;
    logic [ADDRESS_SIZE_IFM-1:0] ifm_address_q;
    logic                        win_q, conv_enable_q;
    logic [CONV_LATENCY-1:0]     ofm_sr_q;
    logic                        busy_q, done_q;

    // Next-state and counter update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        filter_d = filter_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_LOAD_WM;
                    cnt_d    = '0;
                    filter_d = '0;
                end
            end
            S_LOAD_WM: begin
                if (cnt_q == CNT_W'(K2 - 1)) begin
                    state_d = S_STREAM;
                    cnt_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (cnt_q == CNT_W'(N2 - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (c_q == RC_W'(IFM_SIZE - 1)) begin
                        c_d = '0;
                        r_d = r_q + RC_W'(1);
                    end else begin
                        c_d = c_q + RC_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (filter_q == FLT_W'(NUMBER_OF_FILTERS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_LOAD_WM;
                    cnt_d    = '0;
                    filter_d = filter_q + FLT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel being read this cycle completes a full KxK window
    always_comb begin
        win_c = (state_q == S_STREAM) &&
                (r_q >= RC_W'(KERNAL_SIZE - 1)) && (c_q >= RC_W'(KERNAL_SIZE - 1));
    end

    // OFM address: reload to the filter base on LOAD_WM entry, step after each write
    always_comb begin
        ofm_address_d = ofm_address_q;
        if ((state_q != S_LOAD_WM) && (state_d == S_LOAD_WM)) begin
            ofm_address_d = ADDRESS_SIZE_OFM'(filter_d) * ADDRESS_SIZE_OFM'(NEXT2);
        end else if (ofm_sr_q[CONV_LATENCY-1]) begin
            ofm_address_d = ofm_address_q + ADDRESS_SIZE_OFM'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            r_q               <= '0;
            c_q               <= '0;
            filter_q          <= '0;
            ofm_address_q     <= '0;
            wm_enable_read_q  <= 1'b0;
            wm_fifo_enable_q  <= 1'b0;
            wm_address_q      <= '0;
            ifm_enable_read_q <= 1'b0;
            fifo_enable_q     <= 1'b0;
            ifm_address_q     <= '0;
            win_q             <= 1'b0;
            conv_enable_q     <= 1'b0;
            ofm_sr_q          <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            r_q               <= r_d;
            c_q               <= c_d;
            filter_q          <= filter_d;
            ofm_address_q     <= ofm_address_d;
            wm_enable_read_q  <= (state_d == S_LOAD_WM);
            if (state_d == S_LOAD_WM) begin
                wm_address_q <= ADDRESS_BITS'(filter_d) * ADDRESS_BITS'(K2) + ADDRESS_BITS'(cnt_d);
            end
            ifm_enable_read_q <= (state_d == S_STREAM);
            if (state_d == S_STREAM) begin
                ifm_address_q <= ADDRESS_SIZE_IFM'(cnt_d);
            end
            wm_fifo_enable_q  <= wm_enable_read_q;
            fifo_enable_q     <= ifm_enable_read_q;
            win_q             <= win_c;
            conv_enable_q     <= win_q;
            ofm_sr_q[0]       <= conv_enable_q;
            for (int unsigned i = 1; i < CONV_LATENCY; i++) begin
                ofm_sr_q[i] <= ofm_sr_q[i-1];
            end
            busy_q            <= (state_d != S_IDLE);
            done_q            <= (state_d == S_NEXT) && (filter_d == FLT_W'(NUMBER_OF_FILTERS - 1));
        end
    end

    assign bus.wm_enable_read   = wm_enable_read_q;
    assign bus.wm_fifo_enable   = wm_fifo_enable_q;
    assign bus.wm_address       = wm_address_q;
    assign bus.ifm_enable_read  = ifm_enable_read_q;
    assign bus.fifo_enable      = fifo_enable_q;
    assign bus.ifm_address      = ifm_address_q;
    assign bus.conv_enable      = conv_enable_q;
    assign bus.ofm_enable_write = ofm_sr_q[CONV_LATENCY-1];
    assign bus.ofm_address      = ofm_address_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
endmodule

// File: tb/tb_conv_a2_sequencer.sv
// Bench for conv_a2_sequencer: small-parameter instance checked cycle by cycle
// against a timeline model, plus a default-parameter instance for pass totals.
module tb_conv_a2_sequencer;
    localparam int N    = 6;
    localparam int K    = 3;
    localparam int F    = 2;
    localparam int LAT  = 2;
    localparam int N2   = N * N;
    localparam int K2   = K * K;
    localparam int NX   = N - K + 1;
    localparam int NX2  = NX * NX;
    localparam int P    = K2 + N2 + (LAT + 2) + 1;
    localparam int AIFM = $clog2(N2);
    localparam int AOFM = $clog2(F * NX2);

    localparam int LN   = 32;
    localparam int LK   = 5;
    localparam int LF   = 6;
    localparam int LNX  = LN - LK + 1;
    localparam int LP   = LK * LK + LN * LN + 4 + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    conv_a2_sequencer_if #(.ADDRESS_BITS(15), .ADDRESS_SIZE_IFM(AIFM), .ADDRESS_SIZE_OFM(AOFM)) bs ();
    conv_a2_sequencer_if #(.ADDRESS_BITS(15), .ADDRESS_SIZE_IFM(10), .ADDRESS_SIZE_OFM(13)) bl ();

    conv_a2_sequencer #(
        .IFM_SIZE(N), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(F), .ADDRESS_BITS(15), .CONV_LATENCY(LAT)
    ) dut_s (.clk(clk), .reset(reset), .bus(bs));

    conv_a2_sequencer dut_l (.clk(clk), .reset(reset), .bus(bl));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit wm_rd, wm_fifo, ifm_rd, fifo, conv, we, done, busy;
        int wm_addr, ifm_addr, ofm_addr;
    } obs_t;

    typedef struct {
        int   o;
        obs_t e;
    } vec_t;

    obs_t trace [0:F*P+3];
    vec_t tbl [15];

    function automatic obs_t sample();
        obs_t a;
        a.wm_rd    = bs.wm_enable_read;
        a.wm_fifo  = bs.wm_fifo_enable;
        a.ifm_rd   = bs.ifm_enable_read;
        a.fifo     = bs.fifo_enable;
        a.conv     = bs.conv_enable;
        a.we       = bs.ofm_enable_write;
        a.done     = bs.done;
        a.busy     = bs.busy;
        a.wm_addr  = int'(bs.wm_address);
        a.ifm_addr = int'(bs.ifm_address);
        a.ofm_addr = int'(bs.ofm_address);
        return a;
    endfunction

    function automatic obs_t zero_obs();
        obs_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Pixel index p (row-major) completes a KxK window
    function automatic bit win(int p);
        return (p >= 0) && (p < N2) && (p / N >= K - 1) && (p % N >= K - 1);
    endfunction

    // Expected outputs o cycles after the cycle in which start was sampled
    function automatic obs_t model(int o);
        obs_t e;
        int f, w, p;
        e = zero_obs();
        if (o < 0 || o >= F * P) return e;
        f = o / P;
        w = o % P;
        e.busy = 1'b1;
        if (w < K2) begin
            e.wm_rd   = 1'b1;
            e.wm_addr = f * K2 + w;
        end
        e.wm_fifo = (w >= 1) && (w <= K2);
        if (w >= K2 && w < K2 + N2) begin
            e.ifm_rd   = 1'b1;
            e.ifm_addr = w - K2;
        end
        p = w - K2 - 1;
        e.fifo = (p >= 0) && (p < N2);
        e.conv = win(w - K2 - 2);
        p = w - K2 - 2 - LAT;
        if (win(p)) begin
            e.we       = 1'b1;
            e.ofm_addr = f * NX2 + (p / N - (K - 1)) * NX + (p % N - (K - 1));
        end
        e.done = (w == P - 1) && (f == F - 1);
        return e;
    endfunction

    function automatic string fmt(obs_t x);
        return $sformatf("wm=%0b/%0d wf=%0b ifm=%0b/%0d ff=%0b cv=%0b we=%0b/%0d dn=%0b bz=%0b",
                         x.wm_rd, x.wm_addr, x.wm_fifo, x.ifm_rd, x.ifm_addr, x.fifo,
                         x.conv, x.we, x.ofm_addr, x.done, x.busy);
    endfunction

    // Addresses matter only while their strobe is expected, unless strict
    function automatic bit agree(obs_t a, obs_t e, bit strict);
        bit ok;
        ok = (a.wm_rd == e.wm_rd) && (a.wm_fifo == e.wm_fifo) && (a.ifm_rd == e.ifm_rd) &&
             (a.fifo == e.fifo) && (a.conv == e.conv) && (a.we == e.we) &&
             (a.done == e.done) && (a.busy == e.busy);
        if (strict || e.wm_rd)  ok = ok && (a.wm_addr == e.wm_addr);
        if (strict || e.ifm_rd) ok = ok && (a.ifm_addr == e.ifm_addr);
        if (strict || e.we)     ok = ok && (a.ofm_addr == e.ofm_addr);
        return ok;
    endfunction

    task automatic check(input string name, input obs_t a, input obs_t e, input bit strict);
        n_checks++;
        if (!agree(a, e, strict)) begin
            n_fail++;
            $display("FAIL %s: got %s, required %s", name, fmt(a), fmt(e));
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic vec_t mk(int o, bit wm_rd, int wm_addr, bit wm_fifo, bit ifm_rd, int ifm_addr,
                                bit fifo, bit conv, bit we, int ofm_addr, bit done, bit busy);
        vec_t v;
        v.o = o;
        v.e = '{wm_rd: wm_rd, wm_fifo: wm_fifo, ifm_rd: ifm_rd, fifo: fifo, conv: conv, we: we,
                done: done, busy: busy, wm_addr: wm_addr, ifm_addr: ifm_addr, ofm_addr: ofm_addr};
        return v;
    endfunction

    // Pulse start, then compare every cycle of the pass against the model
    task automatic run_pass(input bit noisy, input string tag);
        bs.start = 1'b1;
        @(posedge clk); #1;
        bs.start = 1'b0;
        for (int o = 0; o <= F * P + 3; o++) begin
            trace[o] = sample();
            check($sformatf("%s_cyc%0d", tag, o), trace[o], model(o), 1'b0);
            bs.start = noisy && (o < F * P) && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        bs.start = 1'b0;
    endtask

    initial begin
        int writes, last_addr, dones, done_cyc;
        reset    = 1'b0;
        bs.start = 1'b0;
        bl.start = 1'b0;

        //         o    wr wma  wf ir ima ff cv we oa  dn bz
        tbl[0]  = mk(0,   1, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1);
        tbl[1]  = mk(8,   1, 8,  1, 0, 0,  0, 0, 0, 0,  0, 1);
        tbl[2]  = mk(9,   0, 0,  1, 1, 0,  0, 0, 0, 0,  0, 1);
        tbl[3]  = mk(24,  0, 0,  0, 1, 15, 1, 0, 0, 0,  0, 1);
        tbl[4]  = mk(25,  0, 0,  0, 1, 16, 1, 1, 0, 0,  0, 1);
        tbl[5]  = mk(27,  0, 0,  0, 1, 18, 1, 1, 1, 0,  0, 1);
        tbl[6]  = mk(46,  0, 0,  0, 0, 0,  0, 1, 1, 13, 0, 1);
        tbl[7]  = mk(48,  0, 0,  0, 0, 0,  0, 0, 1, 15, 0, 1);
        tbl[8]  = mk(49,  0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 1);
        tbl[9]  = mk(50,  1, 9,  0, 0, 0,  0, 0, 0, 0,  0, 1);
        tbl[10] = mk(77,  0, 0,  0, 1, 18, 1, 1, 1, 16, 0, 1);
        tbl[11] = mk(98,  0, 0,  0, 0, 0,  0, 0, 1, 31, 0, 1);
        tbl[12] = mk(99,  0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        tbl[13] = mk(100, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0);
        tbl[14] = mk(58,  1, 17, 1, 0, 0,  0, 0, 0, 0,  0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", sample(), zero_obs(), 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", sample(), zero_obs(), 1'b1);

        run_pass(1'b0, "p1");
        for (int i = 0; i < 15; i++) begin
            check($sformatf("tbl_o%0d", tbl[i].o), trace[tbl[i].o], tbl[i].e, 1'b0);
        end

        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        run_pass(1'b1, "p2_noisy_start");

        // Async reset in the middle of filter 1's IFM stream
        bs.start = 1'b1;
        @(posedge clk); #1;
        bs.start = 1'b0;
        repeat (P + K2 + 10) @(posedge clk);
        #1;
        check_int("pre_reset_streaming", int'(bs.ifm_enable_read), 1);
        #3 reset = 1'b0;
        #1 check("async_reset_outputs", sample(), zero_obs(), 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_pass(1'b0, "p3_after_reset");

        // Default-parameter pass totals
        writes = 0; last_addr = -1; dones = 0; done_cyc = -1;
        bl.start = 1'b1;
        @(posedge clk); #1;
        bl.start = 1'b0;
        for (int o = 0; o < LF * LP + 20; o++) begin
            if (bl.ofm_enable_write) begin
                writes++;
                last_addr = int'(bl.ofm_address);
            end
            if (bl.done) begin
                dones++;
                done_cyc = o;
            end
            @(posedge clk); #1;
        end
        check_int("large_total_writes", writes, LF * LNX * LNX);
        check_int("large_last_ofm_address", last_addr, LF * LNX * LNX - 1);
        check_int("large_done_pulses", dones, 1);
        check_int("large_done_cycle", done_cyc, LF * LP - 1);
        check_int("large_busy_after", int'(bl.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_a2_sequencer.md
# conv_a2_sequencer

Control sequencer that drives one ConvA2 convolution unit through a full layer pass. For each filter, it reads the filter's KERNAL_SIZE² weights from the unit's weight memory into the weight FIFO. It then streams the IFM from IFM memory into the unit's line-buffer FIFO, pulses conv_enable on every valid window, and issues OFM memory write strobes aligned to the unit's output. It sits between the RISC-V control interface (start/done) and the unit's enable/address inputs.

## Interface
- IFM_SIZE, 32, input feature-map edge length
- KERNAL_SIZE, 5, kernel edge length
- NUMBER_OF_FILTERS, 6, filters processed per pass
- ADDRESS_BITS, 15, width of wm_address
- CONV_LATENCY, 2, cycles from conv_enable to valid unit_data_out
- IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, output edge length
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), width of ifm_address
- ADDRESS_SIZE_OFM, $clog2(NUMBER_OF_FILTERS*IFM_SIZE_NEXT*IFM_SIZE_NEXT), width of ofm_address

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a pass; ignored unless idle
- ifm_enable_read  output  1  IFM memory read strobe
- ifm_address  output  ADDRESS_SIZE_IFM  IFM read address, row-major
- fifo_enable  output  1  push into unit IFM FIFO
- conv_enable  output  1  unit computes on current window
- wm_enable_read  output  1  weight memory read strobe
- wm_fifo_enable  output  1  push into unit weight FIFO
- wm_address  output  ADDRESS_BITS  weight address = filter*KERNAL_SIZE² + k
- ofm_enable_write  output  1  OFM memory write strobe
- ofm_address  output  ADDRESS_SIZE_OFM  = filter*IFM_SIZE_NEXT² + output index
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, LOAD_WM, STREAM, DRAIN, NEXT.
- IDLE: all strobes low. start=1 → LOAD_WM, filter=0.
- LOAD_WM: KERNAL_SIZE² consecutive cycles with wm_enable_read=1, k=0..K²-1 → STREAM.
- STREAM: IFM_SIZE² consecutive cycles with ifm_enable_read=1, address 0..IFM_SIZE²-1; row counter r and column counter c track the pixel read → DRAIN.
- DRAIN: wait until the filter's last ofm write is issued → NEXT.
- NEXT: one cycle. If filter = NUMBER_OF_FILTERS-1: pulse done and go to IDLE. Otherwise filter+1 and go to LOAD_WM.
- Memory read latency is 1 cycle:
  - fifo_enable is ifm_enable_read delayed 1 cycle.
  - wm_fifo_enable is wm_enable_read delayed 1 cycle.
- Window valid: the pixel at (r,c) has r ≥ K-1 and c ≥ K-1. conv_enable is asserted 1 cycle after that pixel's fifo_enable.
- ofm_enable_write is conv_enable delayed by CONV_LATENCY (shift register). ofm_address increments by 1 after each write and starts at filter*IFM_SIZE_NEXT² for each filter.
- Per filter: exactly K² weight pushes, IFM_SIZE² IFM pushes, IFM_SIZE_NEXT² conv_enables and IFM_SIZE_NEXT² writes.
- start while busy: ignored.
- Reset (any time, including mid-pass): state IDLE; all outputs, counters and delay lines 0 immediately. Pipelined strobes are discarded.

## Timing
- Reset values: every output 0.
- start sampled at edge T → first wm_enable_read in cycle T+1; busy=1 from T+1.
- The last wm_fifo_enable coincides with the first ifm_enable_read cycle.
- conv_enable → ofm_enable_write: exactly CONV_LATENCY cycles.
- DRAIN length: CONV_LATENCY+2 cycles after the last STREAM cycle.
- done high for 1 cycle in NEXT of the last filter; busy drops the following cycle.
- No strobe is ever X after reset. Counters wrap only via explicit reload at state entry.

## Test plan
- Params IFM_SIZE=6, K=3, filters=2, latency 2; pulse start → per filter 9 wm reads (addr 0–8, then 9–17), 36 ifm reads, 16 conv_enables, 16 writes; ofm_address 0–15 then 16–31; one done pulse.
- Check conv_enable pattern: first assertion one cycle after pushing pixel (2,2), address 14; none for c<2 in any row.
- Alignment: every ofm_enable_write occurs exactly 2 cycles after a conv_enable; fifo_enable and wm_fifo_enable each trail their read strobe by 1 cycle.
- start pulsed again mid-STREAM → ignored; counts and done timing unchanged.
- reset asserted mid-STREAM of filter 1 → all outputs 0 asynchronously. After release, a new start restarts at wm_address 0 and ofm_address 0.
- Default params (32,5,6): total 784 writes per filter and 4704 per pass; the last ofm_address is 4703.
